oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- Bus-sharing controller between the cpu6502 core and a 256-byte page-copy DMA engine, in the style of the NES OAM DMA.
- A CPU write to TRIG_ADDR latches a source page, halts the CPU via RDY, then copies 256 bytes from {page,8'h00..8'hFF} to the fixed DEST_ADDR.
- Sits between the CPU bus pins (addr/odata/rw) and the memory/ROM/peripheral bus, and owns the bus mux.

Parameters:
- TRIG_ADDR, 16'h4014, CPU write address that starts a DMA (write data = source page).
- DEST_ADDR, 16'h2004, destination address written on every DMA write cycle.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- cyc_stb  in  1  one-clk pulse marking the end of each CPU bus cycle (falling edge of phi2)
- cpu_addr  in  16  CPU address
- cpu_odata  in  8  CPU write data
- cpu_rw  in  1  CPU direction, 1=read
- cpu_rdy  out  1  RDY to CPU, 0=halt
- bus_addr  out  16  shared bus address
- bus_wdata  out  8  shared bus write data
- bus_rw  out  1  shared bus direction, 1=read
- bus_rdata  in  8  shared bus read data
- dma_busy  out  1  high while the DMA owns the bus

Behaviour:
- Decided interface: one clock `clk`; `reset` is synchronous and active-low. All state updates on posedge clk. With reset==0, the block forces:
  - state=IDLE, cpu_rdy=1, dma_busy=0, idx=0, page=0, parity=0, data latch=0.
- States: IDLE, HALT, ALIGN, READ, WRITE. All transitions occur only on clocks where cyc_stb==1.
- Parity: a 1-bit toggle that flips on every cyc_stb (never gated), counting CPU cycles since reset.
- IDLE:
  - Bus passthrough: bus_addr=cpu_addr, bus_wdata=cpu_odata, bus_rw=cpu_rw.
  - On a strobe with cpu_rw==0 and cpu_addr==TRIG_ADDR: page<=cpu_odata, idx<=0, go to HALT.
- HALT:
  - cpu_rdy=0; bus still in passthrough, because the 6502 completes write cycles despite RDY.
  - On a strobe with cpu_rw==1: go to ALIGN if that cycle's parity is 1 (feature enabled), else go to READ.
  - Writes to TRIG_ADDR while in HALT are ignored.
- ALIGN: DMA owns the bus; bus_addr=DEST_ADDR, bus_rw=1 (dummy read). Next strobe goes to READ.
- READ: bus_addr={page,idx}, bus_rw=1. On the strobe, latch bus_rdata and go to WRITE.
- WRITE: bus_addr=DEST_ADDR, bus_wdata=latch, bus_rw=0. On the strobe:
  - idx<=idx+1, with 8-bit wrap.
  - If idx==8'hFF: go to IDLE (cpu_rdy=1 from the next clk), else go to READ.
- Outputs while the DMA owns the bus:
  - dma_busy=1 in ALIGN/READ/WRITE.
  - cpu_rdy=0 in HALT/ALIGN/READ/WRITE.
  - Mux selection is combinational from state.
- Length is always exactly 256 reads + 256 writes.
- Page 8'hFF is legal: source addresses are 16'hFF00–16'hFFFF with no wrap into page 0.
- Reset asserted mid-transfer aborts immediately to IDLE with passthrough restored. No partial-state retention.
- No latency from trigger to HALT beyond the trigger strobe itself. cpu_rdy falls on the clk after the trigger strobe.

Optional Feature:
- Macro: OAM_DMA_PARITY_ALIGN_EN.
- Defined: the ALIGN cycle is inserted when the halted read cycle has parity 1. Transfer = 513 or 514 owned strobes after HALT, counting the halt read.
- Undefined: ALIGN is never entered, and the parity register is not built. The transfer always goes HALT→READ.

Decomposition:
- Shared package/include oam_dma_defs:
  - state encoding constants (IDLE=3'd0, HALT=3'd1, ALIGN=3'd2, READ=3'd3, WRITE=3'd4);
  - default TRIG_ADDR/DEST_ADDR constants.
- One natural sub-module, oam_dma_busmux: a combinational selection of bus_addr/bus_wdata/bus_rw from state, page, idx, latch and CPU signals.
- FSM, counter and latch stay in oam_dma_ctrl.

Test Plan:
- Page copy: ROM returns (addr[7:0]^8'h5A); CPU writes 8'h02 to 16'h4014, then reads → 256 writes to 16'h2004 with data idx^8'h5A in order. Sources are 16'h0200..16'h02FF. cpu_rdy=1 again after the last write strobe.
- Write-in-HALT: trigger followed by two CPU write cycles (16'h0080←8'h01, 16'h0081←8'hFF) → both appear on the bus in passthrough with cpu_rdy=0. DMA starts only after the next read cycle.
- Parity (macro defined): trigger such that the halted read has parity 1 → exactly one ALIGN strobe with bus_addr=16'h2004, bus_rw=1. With parity 0 → no ALIGN, and dma_busy is high for exactly 512 strobes.
- Boundary page: page 8'hFF → last read at 16'hFFFF, then idx wraps to 0 and the block returns to IDLE. No read of 16'h0000.
- Reset mid-transfer: drive reset=0 at idx=8'h40 in WRITE → next clk: IDLE, cpu_rdy=1, dma_busy=0, bus_addr==cpu_addr. A following trigger restarts at idx 0.
- Non-trigger access: a CPU write of 8'h02 to 16'h4015 and a CPU read of 16'h4014 → no state change, cpu_rdy stays 1.

Source files
------------

// File: rtl/oam_dma_defs.sv
// Shared definitions for the OAM page-copy DMA controller: state encoding and default addresses.
// No logic; constants and a small helper only.
// Optional parity alignment is selected by OAM_DMA_PARITY_ALIGN_EN in oam_dma_ctrl.
package oam_dma_defs;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  localparam logic [15:0] TRIG_ADDR_DEF = 16'h4014;
  localparam logic [15:0] DEST_ADDR_DEF = 16'h2004;

  // True in the states where the DMA engine drives the shared bus.
  function automatic logic dma_owns_bus(state_t s);
    return (s == ST_ALIGN) || (s == ST_READ) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/oam_dma_busmux.sv
// Shared-bus selector: CPU passthrough in IDLE/HALT, DMA source/destination cycles otherwise.
// Purely combinational, zero latency.
// No backpressure; the CPU is held off by cpu_rdy in the controller.
module oam_dma_busmux
  import oam_dma_defs::*;
#(
  parameter logic [15:0] DEST_ADDR = DEST_ADDR_DEF
) (
  input  state_t      state_i,
  input  logic [7:0]  page_i,
  input  logic [7:0]  idx_i,
  input  logic [7:0]  latch_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_odata_i,
  input  logic        cpu_rw_i,
  output logic [15:0] bus_addr_o,
  output logic [7:0]  bus_wdata_o,
  output logic        bus_rw_o
);

  // Select the bus driver from the controller state; HALT stays passthrough so
  // CPU write cycles that ignore RDY still reach the bus.
  always_comb begin
    bus_addr_o  = cpu_addr_i;
    bus_wdata_o = cpu_odata_i;
    bus_rw_o    = cpu_rw_i;
    case (state_i)
      ST_ALIGN: begin
        bus_addr_o  = DEST_ADDR;
        bus_wdata_o = latch_i;
        bus_rw_o    = 1'b1;
      end
      ST_READ: begin
        bus_addr_o  = {page_i, idx_i};
        bus_wdata_o = latch_i;
        bus_rw_o    = 1'b1;
      end
      ST_WRITE: begin
        bus_addr_o  = DEST_ADDR;
        bus_wdata_o = latch_i;
        bus_rw_o    = 1'b0;
      end
      default: begin
        bus_addr_o  = cpu_addr_i;
        bus_wdata_o = cpu_odata_i;
        bus_rw_o    = cpu_rw_i;
      end
    endcase
  end

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM-style DMA: a CPU write to TRIG_ADDR halts the CPU and copies page {src,00..FF} to DEST_ADDR.
// One bus cycle per cyc_stb; cpu_rdy drops the clk after the trigger strobe.
// CPU is stalled via cpu_rdy; OAM_DMA_PARITY_ALIGN_EN adds a dummy cycle on odd-parity halts.
module oam_dma_ctrl
  import oam_dma_defs::*;
#(
  parameter logic [15:0] TRIG_ADDR = TRIG_ADDR_DEF,
  parameter logic [15:0] DEST_ADDR = DEST_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cyc_stb,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_odata,
  input  logic        cpu_rw,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_rw,
  input  logic [7:0]  bus_rdata,
  output logic        dma_busy
);

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] page_q, page_d;
  logic [7:0] latch_q, latch_d;
  logic       align_needed;

`ifdef OAM_DMA_PARITY_ALIGN_EN
  logic parity_q;

  // CPU-cycle parity since reset; toggles on every strobe regardless of state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else if (cyc_stb) begin
      parity_q <= ~parity_q;
    end
  end

  assign align_needed = parity_q;
`else
  assign align_needed = 1'b0;
`endif

  // Next-state: transitions only on a CPU cycle strobe.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    page_d  = page_q;
    latch_d = latch_q;
    if (cyc_stb) begin
      case (state_q)
        ST_IDLE: begin
          if (!cpu_rw && (cpu_addr == TRIG_ADDR)) begin
            page_d  = cpu_odata;
            idx_d   = 8'h00;
            state_d = ST_HALT;
          end
        end
        ST_HALT: begin
          // The CPU only actually stops on a read cycle.
          if (cpu_rw) begin
            state_d = align_needed ? ST_ALIGN : ST_READ;
          end
        end
        ST_ALIGN: begin
          state_d = ST_READ;
        end
        ST_READ: begin
          latch_d = bus_rdata;
          state_d = ST_WRITE;
        end
        ST_WRITE: begin
          idx_d   = idx_q + 8'd1;
          state_d = (idx_q == 8'hFF) ? ST_IDLE : ST_READ;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, counter and data latch registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 8'h00;
      page_q  <= 8'h00;
      latch_q <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      page_q  <= page_d;
      latch_q <= latch_d;
    end
  end

  assign cpu_rdy  = (state_q == ST_IDLE);
  assign dma_busy = dma_owns_bus(state_q);

  oam_dma_busmux #(
    .DEST_ADDR(DEST_ADDR)
  ) u_busmux (
    .state_i    (state_q),
    .page_i     (page_q),
    .idx_i      (idx_q),
    .latch_i    (latch_q),
    .cpu_addr_i (cpu_addr),
    .cpu_odata_i(cpu_odata),
    .cpu_rw_i   (cpu_rw),
    .bus_addr_o (bus_addr),
    .bus_wdata_o(bus_wdata),
    .bus_rw_o   (bus_rw)
  );

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: randomized CPU cycles against a queue-of-bus-operations model.
// Model and DUT are compared on every negedge; directed phases pin counts and boundary addresses.
// Build with OAM_DMA_PARITY_ALIGN_EN defined to exercise the alignment cycle.
module tb_oam_dma_ctrl;

  logic        clk;
  logic        reset;
  logic        cyc_stb;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_odata;
  logic        cpu_rw;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_rw;
  logic [7:0]  bus_rdata;
  logic        dma_busy;

  localparam logic [15:0] DEST = 16'h2004;

  oam_dma_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .cyc_stb  (cyc_stb),
    .cpu_addr (cpu_addr),
    .cpu_odata(cpu_odata),
    .cpu_rw   (cpu_rw),
    .cpu_rdy  (cpu_rdy),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rw   (bus_rw),
    .bus_rdata(bus_rdata),
    .dma_busy (dma_busy)
  );

  // ROM pattern seen by the DMA source reads.
  assign bus_rdata = bus_addr[7:0] ^ 8'h5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [15:0] a;
    logic        rw;
    logic [7:0]  d;
  } op_t;

  op_t  mq[$];
  bit   m_halted = 0;
  bit   m_par = 0;
  bit   started = 0;
  logic [7:0] m_page = 8'h00;

  // Model: a trigger arms a halt; the halted CPU read schedules the whole
  // list of owned bus operations, one consumed per strobe.
  always @(posedge clk) begin
    bit p;
    if (!reset) begin
      started  = 1;
      m_halted = 0;
      m_par    = 0;
      mq.delete();
    end else if (cyc_stb) begin
      p     = m_par;
      m_par = ~m_par;
      if (mq.size() > 0) begin
        void'(mq.pop_front());
      end else if (m_halted) begin
        if (cpu_rw) begin
          m_halted = 0;
`ifdef OAM_DMA_PARITY_ALIGN_EN
          if (p) mq.push_back('{DEST, 1'b1, 8'h00});
`endif
          for (int i = 0; i < 256; i++) begin
            mq.push_back('{{m_page, i[7:0]}, 1'b1, 8'h00});
            mq.push_back('{DEST, 1'b0, i[7:0] ^ 8'h5A});
          end
        end
      end else if (!cpu_rw && cpu_addr == 16'h4014) begin
        m_halted = 1;
        m_page   = cpu_odata;
      end
      if (p === 1'bx) m_par = 0;
    end
  end

  // Compare DUT outputs against the model every cycle.
  always @(negedge clk) begin
    logic [15:0] ea;
    logic        erw, eb, er;
    logic [7:0]  ed;
    if (started) begin
      if (mq.size() > 0) begin
        eb = 1; er = 0; ea = mq[0].a; erw = mq[0].rw; ed = mq[0].d;
      end else begin
        eb = 0; er = !m_halted; ea = cpu_addr; erw = cpu_rw; ed = cpu_odata;
      end
      chk1("cpu_rdy", cpu_rdy, er);
      chk1("dma_busy", dma_busy, eb);
      chk16("bus_addr", bus_addr, ea);
      chk1("bus_rw", bus_rw, erw);
      if (!erw) chk16("bus_wdata", {8'h00, bus_wdata}, {8'h00, ed});
    end
  end

  // ---------------- bus observation ----------------
  int          busy_cnt = 0;
  int          wr_cnt = 0;
  int          zero_rd = 0;
  logic [15:0] last_src = 16'h0000;

  // Tally owned strobes, DMA writes and source addresses.
  always @(posedge clk) begin
    if (reset && cyc_stb && dma_busy) begin
      busy_cnt++;
      if (bus_rw) begin
        if (bus_addr != DEST) last_src = bus_addr;
        if (bus_addr == 16'h0000) zero_rd++;
      end else begin
        wr_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
    int gap;
    gap       = $urandom_range(0, 2);
    cpu_addr  = a;
    cpu_odata = d;
    cpu_rw    = rw;
    cyc_stb   = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    cyc_stb = 1'b1;
    @(posedge clk); #1;
    cyc_stb = 1'b0;
  endtask

  task automatic run_until_idle();
    for (int k = 0; k < 1500 && !cpu_rdy; k++)
      cpu_cycle(16'($urandom), 8'h00, 1'b1);
    chk1("xfer_done", cpu_rdy, 1'b1);
  endtask

  task automatic page_copy(input logic [7:0] pg, input logic [15:0] last_exp);
    int b0, z0;
    b0 = busy_cnt;
    z0 = zero_rd;
    cpu_cycle(16'h4014, pg, 1'b0);
    chk1("rdy_after_trig", cpu_rdy, 1'b0);
    run_until_idle();
`ifdef OAM_DMA_PARITY_ALIGN_EN
    chk1("owned_strobes", (busy_cnt - b0 == 512) || (busy_cnt - b0 == 513), 1'b1);
`else
    chk16("owned_strobes", 16'(busy_cnt - b0), 16'd512);
`endif
    chk16("last_src", last_src, last_exp);
    chk16("zero_reads", 16'(zero_rd - z0), 16'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, vecs %0d", vecs);
    $fatal(1);
  end

  initial begin
    int w0;
    reset     = 1'b0;
    cyc_stb   = 1'b0;
    cpu_addr  = 16'h1234;
    cpu_odata = 8'h00;
    cpu_rw    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk1("reset_rdy", cpu_rdy, 1'b1);
    chk1("reset_busy", dma_busy, 1'b0);
    chk16("reset_addr", bus_addr, 16'h1234);
    reset = 1'b1;

    // Non-trigger accesses.
    cpu_cycle(16'h4015, 8'h02, 1'b0);
    cpu_cycle(16'h4014, 8'h02, 1'b1);
    chk1("nontrig_rdy", cpu_rdy, 1'b1);

    // Writes during HALT pass through and do not start the copy.
    cpu_cycle(16'h4014, 8'h02, 1'b0);
    cpu_cycle(16'h0080, 8'h01, 1'b0);
    cpu_cycle(16'h0081, 8'hFF, 1'b0);
    chk1("halt_wr_busy", dma_busy, 1'b0);
    chk1("halt_wr_rdy", cpu_rdy, 1'b0);
    run_until_idle();
    chk16("p02_last_src", last_src, 16'h02FF);

    // Plain page copies, including the top page.
    page_copy(8'h02, 16'h02FF);
    page_copy(8'hFF, 16'hFFFF);
    page_copy(8'h7C, 16'h7CFF);

    // Reset in the middle of the transfer, at the WRITE of idx 0x40.
    w0 = wr_cnt;
    cpu_cycle(16'h4014, 8'h03, 1'b0);
    for (int k = 0; k < 600 && !((wr_cnt - w0 == 64) && dma_busy && !bus_rw); k++)
      cpu_cycle(16'h0300, 8'h00, 1'b1);
    chk1("reached_idx40", (wr_cnt - w0 == 64) && !bus_rw, 1'b1);
    cpu_addr = 16'hBEEF;
    reset    = 1'b0;
    @(posedge clk); #1;
    chk1("midrst_rdy", cpu_rdy, 1'b1);
    chk1("midrst_busy", dma_busy, 1'b0);
    chk16("midrst_addr", bus_addr, 16'hBEEF);
    reset = 1'b1;

    // Restart starts from idx 0.
    w0 = wr_cnt;
    cpu_cycle(16'h4014, 8'h04, 1'b0);
    for (int k = 0; k < 20 && (wr_cnt - w0 < 1); k++)
      cpu_cycle(16'h0400, 8'h00, 1'b1);
    chk16("restart_src", last_src, 16'h0400);
    run_until_idle();

    // Randomized CPU traffic with occasional triggers.
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2)       cpu_cycle(16'h4014, 8'($urandom), 1'b0);
      else if (r < 55) cpu_cycle(16'($urandom), 8'($urandom), 1'b1);
      else             cpu_cycle(16'($urandom), 8'($urandom), 1'b0);
    end
    run_until_idle();

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
